// File: rtl/rtc_alarm_clock_if.sv
// Purpose: bundles the RTC control, time-load, alarm and display signals.
// Latency: none, wiring only.
// Backpressure: none; every strobe is a single-cycle pulse with no handshake.
interface rtc_alarm_clock_if;
  logic       run;
  logic       mode12;
  logic       load;
  logic [5:0] set_sec;
  logic [5:0] set_min;
  logic [4:0] set_hr;
  logic       alarm_set;
  logic [5:0] alarm_min;
  logic [4:0] alarm_hr;
  logic       alarm_en;
  logic       alarm_ack;
  logic [7:0] seconds;
  logic [7:0] minutes;
  logic [7:0] hours;
  logic       pm;
  logic       tick_1s;
  logic       day_wrap;
  logic       alarm;
  logic       load_err;

  modport slave (
    input  run, mode12, load, set_sec, set_min, set_hr,
    input  alarm_set, alarm_min, alarm_hr, alarm_en, alarm_ack,
    output seconds, minutes, hours, pm, tick_1s, day_wrap, alarm, load_err
  );

  modport master (
    output run, mode12, load, set_sec, set_min, set_hr,
    output alarm_set, alarm_min, alarm_hr, alarm_en, alarm_ack,
    input  seconds, minutes, hours, pm, tick_1s, day_wrap, alarm, load_err
  );
endinterface

// File: rtl/rtc_alarm_clock.sv
// Purpose: prescaled hh:mm:ss real-time clock with 12/24 h and BCD display, validated load, sticky alarm.
// Latency: time, strobes and alarm update on the edge after the tick/load; display is combinational.
// Backpressure: none; load/alarm_set are accepted every cycle, invalid values pulse load_err.
module rtc_alarm_clock #(
  parameter int CLK_HZ = 1,
  parameter int BCD    = 0
) (
  input  logic              clk,
  input  logic              reset,
  rtc_alarm_clock_if.slave  bus
);
  localparam int            PW        = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);

  logic [PW-1:0] r_presc;
  logic [5:0]    r_sec;
  logic [5:0]    r_min;
  logic [4:0]    r_hr;
  logic [5:0]    r_al_min;
  logic [4:0]    r_al_hr;
  logic          r_tick_1s;
  logic          r_day_wrap;
  logic          r_alarm;
  logic          r_load_err;

  logic          w_tick;
  logic          w_load_ok;
  logic          w_load_bad;
  logic          w_aset_ok;
  logic          w_aset_bad;
  logic          w_adv;
  logic [5:0]    w_nsec;
  logic [5:0]    w_nmin;
  logic [4:0]    w_nhr;
  logic          w_nday;
  logic          w_fire;
  logic [4:0]    w_hr12;
  logic [4:0]    w_hr_disp;

  // Values are 0..59, so one division by ten yields both BCD digits.
  function automatic logic [7:0] f_fmt(input logic [5:0] v);
    logic [5:0] t;
    logic [5:0] o;
    t = v / 6'd10;
    o = v - t * 6'd10;
    f_fmt = (BCD != 0) ? {t[3:0], o[3:0]} : {2'b00, v};
  endfunction

  assign w_tick     = bus.run && (r_presc == PRESC_MAX);
  assign w_load_ok  = bus.load && (bus.set_sec < 6'd60) && (bus.set_min < 6'd60) && (bus.set_hr < 5'd24);
  assign w_load_bad = bus.load && !w_load_ok;
  assign w_aset_ok  = bus.alarm_set && (bus.alarm_min < 6'd60) && (bus.alarm_hr < 5'd24);
  assign w_aset_bad = bus.alarm_set && !w_aset_ok;
  // A valid load discards a coincident tick; an invalid one leaves counting untouched.
  assign w_adv      = w_tick && !w_load_ok;

  // Next time of day after one second, with minute/hour carries and midnight wrap.
  always_comb begin
    w_nsec = r_sec + 6'd1;
    w_nmin = r_min;
    w_nhr  = r_hr;
    w_nday = 1'b0;
    if (r_sec == 6'd59) begin
      w_nsec = 6'd0;
      w_nmin = r_min + 6'd1;
      if (r_min == 6'd59) begin
        w_nmin = 6'd0;
        w_nhr  = r_hr + 5'd1;
        if (r_hr == 5'd23) begin
          w_nhr  = 5'd0;
          w_nday = 1'b1;
        end
      end
    end
  end

  assign w_fire = w_adv && bus.alarm_en && (w_nsec == 6'd0) &&
                  (w_nmin == r_al_min) && (w_nhr == r_al_hr);

  // Prescaler: free-runs while run=1, restarts on a valid load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)              r_presc <= '0;
    else if (w_load_ok)     r_presc <= '0;
    else if (bus.run)       r_presc <= (r_presc == PRESC_MAX) ? '0 : r_presc + 1'b1;
  end

  // Time-of-day registers: load has priority over the one-second advance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sec <= '0;
      r_min <= '0;
      r_hr  <= '0;
    end else if (w_load_ok) begin
      r_sec <= bus.set_sec;
      r_min <= bus.set_min;
      r_hr  <= bus.set_hr;
    end else if (w_adv) begin
      r_sec <= w_nsec;
      r_min <= w_nmin;
      r_hr  <= w_nhr;
    end
  end

  // Alarm compare registers, only ever holding validated values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_al_min <= '0;
      r_al_hr  <= '0;
    end else if (w_aset_ok) begin
      r_al_min <= bus.alarm_min;
      r_al_hr  <= bus.alarm_hr;
    end
  end

  // Single-cycle strobes aligned with the updated time.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tick_1s  <= 1'b0;
      r_day_wrap <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_tick_1s  <= w_adv;
      r_day_wrap <= w_adv && w_nday;
      r_load_err <= w_load_bad || w_aset_bad;
    end
  end

  // Sticky alarm flag: a new match wins over a coincident acknowledge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)              r_alarm <= 1'b0;
    else if (w_fire)        r_alarm <= 1'b1;
    else if (bus.alarm_ack) r_alarm <= 1'b0;
  end

  assign w_hr12    = (r_hr == 5'd0) ? 5'd12 : ((r_hr > 5'd12) ? r_hr - 5'd12 : r_hr);
  assign w_hr_disp = bus.mode12 ? w_hr12 : r_hr;

  assign bus.seconds  = f_fmt(r_sec);
  assign bus.minutes  = f_fmt(r_min);
  assign bus.hours    = f_fmt({1'b0, w_hr_disp});
  assign bus.pm       = (r_hr >= 5'd12);
  assign bus.tick_1s  = r_tick_1s;
  assign bus.day_wrap = r_day_wrap;
  assign bus.alarm    = r_alarm;
  assign bus.load_err = r_load_err;
endmodule
